// File: rtl/i2c_reg_sequencer_if.sv
// Table and byte-level I2C master handshake between the register sequencer
// and its surroundings (command table ROM and i2c master).
interface i2c_reg_sequencer_if #(
    parameter int unsigned ADDR_W = 8
) ();
    logic [ADDR_W-1:0] tbl_addr;
    logic [17:0]       tbl_data;
    logic [23:0]       i2c_data;
    logic              i2c_start;
    logic              i2c_end;
    logic              i2c_nack;

    modport master (
        output tbl_addr,
        output i2c_data,
        output i2c_start,
        input  tbl_data,
        input  i2c_end,
        input  i2c_nack
    );

    modport slave (
        input  tbl_addr,
        input  i2c_data,
        input  i2c_start,
        output tbl_data,
        output i2c_end,
        output i2c_nack
    );
endinterface

// File: rtl/i2c_reg_sequencer.sv
// Table-driven I2C register configurator: walks a command table and issues
// {slave, sub-address, data} writes with delays, slave changes and NACK retry.
module i2c_reg_sequencer #(
    parameter logic [7:0]  SLAVE_ADDR = 8'h72,
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned MAX_RETRY  = 3,
    parameter int unsigned DELAY_UNIT = 50_000
) (
    input  logic                       iCLK,
    input  logic                       iRST_N,
    input  logic                       restart,
    i2c_reg_sequencer_if.master        bus,
    output logic                       busy,
    output logic                       done,
    output logic                       error,
    output logic [7:0]                 err_cnt
);

    localparam int unsigned UNIT_W  = (DELAY_UNIT > 1) ? $clog2(DELAY_UNIT) : 1;
    localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int unsigned TICK_W  = 16;

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_DELAY = 2'b01;
    localparam logic [1:0] OP_SLAVE = 2'b10;
    localparam logic [1:0] OP_END   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_REQ, S_RUN, S_DELAY, S_FIN
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   tbl_addr_q, tbl_addr_d;
    logic [7:0]          slave_q, slave_d;
    logic [RETRY_W-1:0]  retry_q, retry_d;
    logic [TICK_W-1:0]   tick_q, tick_d;
    logic [UNIT_W-1:0]   unit_q, unit_d;
    logic                pend_q, pend_d;
    logic                rst_hist_q, rst_hist_d;
    logic [23:0]         i2c_data_q, i2c_data_d;
    logic                i2c_start_q, i2c_start_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
    logic [7:0]          err_cnt_q, err_cnt_d;

    logic                rise_c;
    logic                adv_c;
    logic                restart_now_c;
    logic [1:0]          op_c;
    logic [7:0]          a_c;
    logic [7:0]          d_c;

    assign rise_c = restart & ~rst_hist_q;
    assign op_c   = bus.tbl_data[17:16];
    assign a_c    = bus.tbl_data[15:8];
    assign d_c    = bus.tbl_data[7:0];

    // Next-state, datapath and registered-output computation
    always_comb begin
        state_d       = state_q;
        tbl_addr_d    = tbl_addr_q;
        slave_d       = slave_q;
        retry_d       = retry_q;
        tick_d        = tick_q;
        unit_d        = unit_q;
        pend_d        = pend_q;
        rst_hist_d    = restart;
        i2c_data_d    = i2c_data_q;
        i2c_start_d   = i2c_start_q;
        error_d       = error_q;
        err_cnt_d     = err_cnt_q;
        adv_c         = 1'b0;
        restart_now_c = 1'b0;

        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (op_c)
                    OP_WRITE: begin
                        i2c_data_d  = {slave_q, a_c, d_c};
                        i2c_start_d = 1'b1;
                        state_d     = S_REQ;
                    end
                    OP_DELAY: begin
                        if ({a_c, d_c} == 16'h0000) begin
                            adv_c = 1'b1;
                        end else begin
                            tick_d  = {a_c, d_c};
                            unit_d  = '0;
                            state_d = S_DELAY;
                        end
                    end
                    OP_SLAVE: begin
                        slave_d = d_c;
                        adv_c   = 1'b1;
                    end
                    OP_END:   state_d = S_FIN;
                endcase
            end
            S_REQ: begin
                if (!bus.i2c_end) begin
                    i2c_start_d = 1'b0;
                    state_d     = S_RUN;
                end
            end
            S_RUN: begin
                // A pending restart discards the result of the finished transfer
                if (bus.i2c_end) begin
                    if (pend_q || rise_c) begin
                        restart_now_c = 1'b1;
                    end else if (!bus.i2c_nack) begin
                        retry_d = '0;
                        adv_c   = 1'b1;
                    end else if (retry_q < RETRY_W'(MAX_RETRY)) begin
                        retry_d     = retry_q + RETRY_W'(1);
                        i2c_start_d = 1'b1;
                        state_d     = S_REQ;
                    end else begin
                        error_d = 1'b1;
                        if (err_cnt_q != 8'hFF) begin
                            err_cnt_d = err_cnt_q + 8'd1;
                        end
                        retry_d = '0;
                        adv_c   = 1'b1;
                    end
                end
            end
            S_DELAY: begin
                if (unit_q == UNIT_W'(DELAY_UNIT - 1)) begin
                    unit_d = '0;
                    if (tick_q == TICK_W'(1)) begin
                        adv_c = 1'b1;
                    end else begin
                        tick_d = tick_q - TICK_W'(1);
                    end
                end else begin
                    unit_d = unit_q + UNIT_W'(1);
                end
            end
            S_FIN:    state_d = S_FIN;
            default:  state_d = S_IDLE;
        endcase

        // Last table entry ends the run instead of wrapping the index
        if (adv_c) begin
            if (tbl_addr_q == '1) begin
                state_d = S_FIN;
            end else begin
                tbl_addr_d = tbl_addr_q + ADDR_W'(1);
                state_d    = S_FETCH;
            end
        end

        if (rise_c) begin
            if (state_q == S_REQ || state_q == S_RUN) begin
                pend_d = 1'b1;
            end else begin
                restart_now_c = 1'b1;
            end
        end

        if (restart_now_c) begin
            state_d     = S_FETCH;
            tbl_addr_d  = '0;
            slave_d     = SLAVE_ADDR;
            retry_d     = '0;
            tick_d      = '0;
            unit_d      = '0;
            pend_d      = 1'b0;
            i2c_start_d = 1'b0;
            error_d     = 1'b0;
            err_cnt_d   = 8'h00;
        end

        busy_d = (state_d != S_IDLE) && (state_d != S_FIN);
        done_d = (state_d == S_FIN);
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q     <= S_IDLE;
            tbl_addr_q  <= '0;
            slave_q     <= SLAVE_ADDR;
            retry_q     <= '0;
            tick_q      <= '0;
            unit_q      <= '0;
            pend_q      <= 1'b0;
            rst_hist_q  <= 1'b0;
            i2c_data_q  <= 24'h000000;
            i2c_start_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            err_cnt_q   <= 8'h00;
        end else begin
            state_q     <= state_d;
            tbl_addr_q  <= tbl_addr_d;
            slave_q     <= slave_d;
            retry_q     <= retry_d;
            tick_q      <= tick_d;
            unit_q      <= unit_d;
            pend_q      <= pend_d;
            rst_hist_q  <= rst_hist_d;
            i2c_data_q  <= i2c_data_d;
            i2c_start_q <= i2c_start_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign bus.tbl_addr  = tbl_addr_q;
    assign bus.i2c_data  = i2c_data_q;
    assign bus.i2c_start = i2c_start_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;
    assign err_cnt       = err_cnt_q;

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// Bench for i2c_reg_sequencer: table ROM and i2c master models, scenario tasks
// plus randomized tables checked against a table-walking reference model.
module tb_i2c_reg_sequencer;

    localparam int unsigned AW = 2;
    localparam int unsigned MR = 3;
    localparam int unsigned DU = 10;
    localparam logic [17:0] E_END = {2'b11, 16'h0000};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       restart = 1'b0;
    logic       busy;
    logic       done;
    logic       error;
    logic [7:0] err_cnt;

    int errors = 0;
    int checks = 0;

    logic [17:0] tbl [4];
    logic [23:0] xfers [$];
    bit          plan [$];
    int          xmin = 2;
    int          xmax = 6;
    int          stable_viol = 0;
    logic        m_active;
    int          m_cnt;
    logic [23:0] m_data;

    i2c_reg_sequencer_if #(.ADDR_W(AW)) bus ();

    i2c_reg_sequencer #(
        .SLAVE_ADDR (8'h72),
        .ADDR_W     (AW),
        .MAX_RETRY  (MR),
        .DELAY_UNIT (DU)
    ) dut (
        .iCLK    (clk),
        .iRST_N  (rst_n),
        .restart (restart),
        .bus     (bus),
        .busy    (busy),
        .done    (done),
        .error   (error),
        .err_cnt (err_cnt)
    );

    always #5 clk = ~clk;

    // Synchronous table ROM: data valid one cycle after the index changes
    always @(posedge clk) bus.tbl_data <= tbl[bus.tbl_addr];

    // Byte-level i2c master model: logs each transfer, NACKs from the plan queue
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.i2c_end  <= 1'b1;
            bus.i2c_nack <= 1'b0;
            m_active     <= 1'b0;
            m_cnt        <= 0;
            m_data       <= 24'h0;
        end else if (!m_active) begin
            if (bus.i2c_start === 1'b1) begin
                m_active    <= 1'b1;
                bus.i2c_end <= 1'b0;
                m_cnt       <= $urandom_range(xmax, xmin);
                m_data      <= bus.i2c_data;
                xfers.push_back(bus.i2c_data);
            end
        end else begin
            if (bus.i2c_data !== m_data) stable_viol <= stable_viol + 1;
            if (m_cnt == 0) begin
                m_active    <= 1'b0;
                bus.i2c_end <= 1'b1;
                if (plan.size() > 0) bus.i2c_nack <= plan.pop_front();
                else                 bus.i2c_nack <= 1'b0;
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end
    end

    function automatic logic [17:0] w(input logic [7:0] a, input logic [7:0] d);
        return {2'b00, a, d};
    endfunction

    // Reference: walk the table, one logged transfer per attempt, plan gives NACKs
    function automatic void ref_run(input logic [17:0] t [4], input bit p [$],
                                    output logic [23:0] ex [$], output int ex_err);
        logic [7:0] slave = 8'h72;
        int  pi = 0;
        bit  stop = 0;
        bit  nk;
        ex.delete();
        ex_err = 0;
        for (int i = 0; i < 4 && !stop; i++) begin
            case (t[i][17:16])
                2'b11: stop = 1;
                2'b10: slave = t[i][7:0];
                2'b01: ;
                default: begin
                    for (int att = 0; att <= int'(MR); att++) begin
                        ex.push_back({slave, t[i][15:0]});
                        nk = (pi < p.size()) ? p[pi] : 1'b0;
                        pi++;
                        if (!nk) break;
                        if (att == int'(MR)) ex_err++;
                    end
                end
            endcase
        end
    endfunction

    task automatic set_tbl(input logic [17:0] e0, input logic [17:0] e1,
                           input logic [17:0] e2, input logic [17:0] e3);
        tbl[0] = e0; tbl[1] = e1; tbl[2] = e2; tbl[3] = e3;
    endtask

    task automatic kick();
        @(negedge clk); restart = 1'b1;
        @(negedge clk); restart = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin ok = 1; break; end
        end
    endtask

    task automatic test_reset();
        set_tbl(w(8'h98, 8'h03), w(8'h41, 8'h10), E_END, E_END);
        xfers.delete(); plan.delete();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if ({busy, done, error} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {busy, done, error}); end
        checks++; if (err_cnt !== 8'h00) begin errors++; $display("FAIL reset_err_cnt: got %h want 00", err_cnt); end
        checks++; if (bus.tbl_addr !== 2'd0 || bus.i2c_start !== 1'b0 || bus.i2c_data !== 24'h0) begin
            errors++; $display("FAIL reset_bus: addr=%h start=%b data=%h want 0/0/0", bus.tbl_addr, bus.i2c_start, bus.i2c_data); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_autostart: busy=%b want 1", busy); end
    endtask

    task automatic test_basic();
        bit ok;
        wait_done(ok);
        checks++; if (!ok) begin errors++; $display("FAIL basic_done_timeout: done=%b want 1", done); end
        checks++; if (xfers.size() !== 2) begin errors++; $display("FAIL basic_count: got %0d want 2", xfers.size()); end
        checks++; if (xfers[0] !== 24'h729803) begin errors++; $display("FAIL basic_x0: got %h want 729803", xfers[0]); end
        checks++; if (xfers[1] !== 24'h724110) begin errors++; $display("FAIL basic_x1: got %h want 724110", xfers[1]); end
        checks++; if ({done, error, busy} !== 3'b100) begin errors++; $display("FAIL basic_flags: done/error/busy=%b want 100", {done, error, busy}); end
    endtask

    task automatic test_slave();
        bit ok;
        set_tbl({2'b10, 8'h00, 8'h7A}, w(8'h02, 8'h55), E_END, E_END);
        xfers.delete(); plan.delete();
        kick(); wait_done(ok);
        checks++; if (!ok || xfers.size() !== 1) begin errors++; $display("FAIL slave_count: ok=%b got %0d want 1", ok, xfers.size()); end
        checks++; if (xfers[0] !== 24'h7A0255) begin errors++; $display("FAIL slave_data: got %h want 7A0255", xfers[0]); end
        set_tbl(w(8'h02, 8'h55), E_END, E_END, E_END);
        xfers.delete();
        kick(); wait_done(ok);
        checks++; if (!ok || xfers[0] !== 24'h720255) begin errors++; $display("FAIL slave_after_restart: ok=%b got %h want 720255", ok, xfers[0]); end
    endtask

    task automatic test_retry();
        bit ok;
        set_tbl(w(8'h10, 8'h01), w(8'h11, 8'h02), E_END, E_END);
        xfers.delete();
        plan = '{1, 1, 1, 1, 1, 1, 0};
        kick(); wait_done(ok);
        checks++; if (!ok || xfers.size() !== 7) begin errors++; $display("FAIL retry_count: ok=%b got %0d want 7", ok, xfers.size()); end
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (xfers[i] !== ((i < 4) ? 24'h721001 : 24'h721102)) begin
                errors++; $display("FAIL retry_x%0d: got %h want %h", i, xfers[i], (i < 4) ? 24'h721001 : 24'h721102); end
        end
        checks++; if (error !== 1'b1 || err_cnt !== 8'd1) begin errors++; $display("FAIL retry_err: error=%b cnt=%0d want 1/1", error, err_cnt); end
    endtask

    task automatic test_delay();
        bit ok;
        int n;
        int ticks;
        for (int k = 0; k < 2; k++) begin
            ticks = (k == 0) ? 3 : 0;
            set_tbl({2'b01, 16'(ticks)}, w(8'h10, 8'h20), E_END, E_END);
            xfers.delete(); plan.delete();
            @(negedge clk); restart = 1'b1;
            @(posedge clk); #1; n = 0;
            @(negedge clk); restart = 1'b0;
            while (bus.i2c_start !== 1'b1 && n < 500) begin @(posedge clk); #1; n++; end
            checks++; if (n !== 4 + ticks * int'(DU)) begin errors++; $display("FAIL delay_latency_%0d: got %0d want %0d", ticks, n, 4 + ticks * int'(DU)); end
            wait_done(ok);
            checks++; if (!ok || xfers[0] !== 24'h721020) begin errors++; $display("FAIL delay_data_%0d: ok=%b got %h want 721020", ticks, ok, xfers[0]); end
        end
    endtask

    task automatic test_restart_run();
        bit ok;
        int n;
        set_tbl(w(8'h10, 8'h01), w(8'h11, 8'h02), w(8'h12, 8'h03), E_END);
        xfers.delete();
        plan = '{1, 1, 1, 1, 0, 1};
        xmin = 12; xmax = 14;
        kick();
        n = 0;
        while (!(bus.tbl_addr == 2'd2 && bus.i2c_end == 1'b0) && n < 3000) begin @(negedge clk); n++; end
        checks++; if (n >= 3000) begin errors++; $display("FAIL rst_reach_entry2: timeout addr=%0d want 2", bus.tbl_addr); end
        checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL rst_pre_err_cnt: got %0d want 1", err_cnt); end
        restart = 1'b1; @(negedge clk); restart = 1'b0; @(negedge clk);
        restart = 1'b1; @(negedge clk); restart = 1'b0;
        n = 0;
        while (bus.i2c_end !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        checks++; if (bus.tbl_addr !== 2'd0) begin errors++; $display("FAIL rst_addr: got %0d want 0", bus.tbl_addr); end
        checks++; if (err_cnt !== 8'd0 || error !== 1'b0) begin errors++; $display("FAIL rst_clear: cnt=%0d error=%b want 0/0", err_cnt, error); end
        checks++; if (xfers.size() !== 6) begin errors++; $display("FAIL rst_pre_count: got %0d want 6", xfers.size()); end
        xmin = 2; xmax = 6;
        wait_done(ok);
        checks++; if (!ok || xfers.size() !== 9) begin errors++; $display("FAIL rst_total: ok=%b got %0d want 9", ok, xfers.size()); end
        checks++; if (xfers[6] !== 24'h721001 || xfers[8] !== 24'h721203) begin
            errors++; $display("FAIL rst_rerun_data: got %h/%h want 721001/721203", xfers[6], xfers[8]); end
        checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL rst_final_cnt: got %0d want 0", err_cnt); end
    endtask

    task automatic test_full_table();
        bit ok;
        set_tbl(w(8'h20, 8'h01), w(8'h21, 8'h02), w(8'h22, 8'h03), w(8'h23, 8'h04));
        xfers.delete(); plan.delete();
        kick(); wait_done(ok);
        checks++; if (!ok || xfers.size() !== 4) begin errors++; $display("FAIL full_count: ok=%b got %0d want 4", ok, xfers.size()); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (xfers[i] !== {8'h72, 8'(8'h20 + i), 8'(i + 1)}) begin
                errors++; $display("FAIL full_x%0d: got %h want %h", i, xfers[i], {8'h72, 8'(8'h20 + i), 8'(i + 1)}); end
        end
        repeat (20) @(negedge clk);
        checks++; if (bus.tbl_addr !== 2'd3 || done !== 1'b1 || xfers.size() !== 4) begin
            errors++; $display("FAIL full_no_wrap: addr=%0d done=%b count=%0d want 3/1/4", bus.tbl_addr, done, xfers.size()); end
    endtask

    task automatic test_random();
        bit ok;
        int r;
        int ex_err;
        logic [23:0] ex [$];
        for (int it = 0; it < 8; it++) begin
            for (int i = 0; i < 4; i++) begin
                r = $urandom_range(0, 9);
                if (r < 5)      tbl[i] = {2'b00, 8'($urandom), 8'($urandom)};
                else if (r < 7) tbl[i] = {2'b01, 8'h00, 8'($urandom_range(0, 2))};
                else if (r < 9) tbl[i] = {2'b10, 8'h00, 8'($urandom)};
                else            tbl[i] = E_END;
            end
            plan.delete(); xfers.delete();
            for (int i = 0; i < 24; i++) plan.push_back($urandom_range(0, 9) < 3);
            ref_run(tbl, plan, ex, ex_err);
            kick(); wait_done(ok);
            checks++; if (!ok || xfers.size() !== ex.size()) begin errors++; $display("FAIL rand%0d_count: ok=%b got %0d want %0d", it, ok, xfers.size(), ex.size()); end
            for (int i = 0; i < ex.size() && i < xfers.size(); i++) begin
                checks++; if (xfers[i] !== ex[i]) begin errors++; $display("FAIL rand%0d_x%0d: got %h want %h", it, i, xfers[i], ex[i]); end
            end
            checks++; if (err_cnt !== 8'(ex_err) || error !== (ex_err > 0)) begin
                errors++; $display("FAIL rand%0d_err: cnt=%0d error=%b want %0d/%b", it, err_cnt, error, ex_err, ex_err > 0); end
        end
    endtask

    task automatic test_async_reset();
        bit ok;
        int n;
        set_tbl(w(8'h98, 8'h03), w(8'h41, 8'h10), E_END, E_END);
        plan.delete();
        kick();
        n = 0;
        while (bus.i2c_end !== 1'b0 && n < 200) begin @(negedge clk); n++; end
        rst_n = 1'b0; #1;
        checks++; if (bus.i2c_start !== 1'b0 || busy !== 1'b0 || bus.tbl_addr !== 2'd0 || bus.i2c_data !== 24'h0) begin
            errors++; $display("FAIL async_reset: start=%b busy=%b addr=%0d data=%h want 0", bus.i2c_start, busy, bus.tbl_addr, bus.i2c_data); end
        @(negedge clk);
        xfers.delete();
        rst_n = 1'b1;
        wait_done(ok);
        checks++; if (!ok || xfers.size() !== 2 || xfers[1] !== 24'h724110) begin
            errors++; $display("FAIL async_rerun: ok=%b count=%0d last=%h want 2/724110", ok, xfers.size(), xfers[1]); end
        checks++; if (stable_viol !== 0) begin errors++; $display("FAIL data_stable: %0d changes during transfers want 0", stable_viol); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_slave();
        test_retry();
        test_delay();
        test_restart_run();
        test_full_table();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/i2c_reg_sequencer.md
# i2c_reg_sequencer

Table-driven I2C register configurator: walks an external command table and issues 3-byte writes {slave, sub-address, data} through the existing byte-level `i2c` master, with programmable delays, per-entry slave-address changes, bounded NACK retry and re-run on request. It is the generalised successor to the fixed ADV7513 init sequencer, serving HDMI transmitter, audio codec and other board-level I2C peripherals from one block.

## Interface
Parameters:
- `SLAVE_ADDR`, 8'h72: 8-bit write address in effect after reset/restart; `OP_SLAVE` entries change it.
- `ADDR_W`, 8: table index width; the table holds 2^ADDR_W entries.
- `MAX_RETRY`, 3: retries per entry after the first NACK (total attempts = MAX_RETRY+1).
- `DELAY_UNIT`, 50_000: clock cycles per delay tick (1 ms at 50 MHz).

Ports:
- `iCLK`  in  1  system clock.
- `iRST_N`  in  1  asynchronous, active-low reset.
- `restart`  in  1  rising edge re-runs the table from index 0, e.g. HPD reconnect.
- `tbl_addr`  out  ADDR_W  table index, registered.
- `tbl_data`  in  18  entry {op[1:0], a[7:0], d[7:0]}; valid one cycle after `tbl_addr` changes.
- `i2c_data`  out  24  {slave, a, d} to the i2c master.
- `i2c_start`  out  1  transfer request.
- `i2c_end`  in  1  master idle/finished; low while a transfer runs.
- `i2c_nack`  in  1  valid when `i2c_end` rises; 1 = transfer not acknowledged.
- `busy`  out  1  sequence in progress.
- `done`  out  1  table completed; held until restart.
- `error`  out  1  sticky: at least one entry exhausted its retries in this run.
- `err_cnt`  out  8  entries skipped after exhausting retries, saturating at 255.

## Operation
- Opcodes: 00 `OP_WRITE` (write a←d); 01 `OP_DELAY` (wait {a,d}×DELAY_UNIT cycles; 0 = no wait); 10 `OP_SLAVE` (slave register ← d, no bus traffic); 11 `OP_END`.
- States: IDLE, FETCH, DECODE, REQ, RUN, DELAY, FIN.
- Reset: all outputs 0, `tbl_addr`=0, slave=SLAVE_ADDR, retry=0. The first cycle after reset release enters FETCH; the sequence starts automatically.
- FETCH: one wait cycle for `tbl_data`, then DECODE.
- DECODE: dispatch by opcode. `OP_SLAVE` and a zero delay advance immediately. `OP_END` enters FIN.
- REQ: drive `i2c_data`, assert `i2c_start`. Hold it until `i2c_end` is seen low, then drop it and enter RUN.
- RUN: wait for `i2c_end` high.
  - Success (`i2c_nack`=0): clear retry, advance.
  - NACK with retry<MAX_RETRY: retry+1, return to REQ on the same entry.
  - NACK with retry=MAX_RETRY: set `error`, increment `err_cnt` (saturating), clear retry, advance.
- Advance: `tbl_addr`+1, then FETCH. If `tbl_addr` is 2^ADDR_W−1, enter FIN instead of wrapping. An implicit end is legal.
- FIN: `busy`=0, `done`=1; stay until restart.
- `busy`=1 in every state except IDLE and FIN.

## Timing
- `restart` is edge-detected with a one-cycle registered history. The history resets to 0.
- Restart edge in FIN, FETCH, DECODE or DELAY: on the next cycle `tbl_addr`=0, slave=SLAVE_ADDR, retry=0, `done`=0, `error`=0, `err_cnt`=0, delay counter cleared; then FETCH.
- Restart edge in REQ or RUN: latch a pending flag. The bus transfer always completes, with no mid-byte abort. When `i2c_end` rises, ignore the result and perform the restart. Further edges while pending are absorbed.
- Minimum per `OP_WRITE` entry: FETCH + DECODE + 1 REQ cycle + the master's transfer time.
- `OP_DELAY` of N ticks holds DELAY for exactly N×DELAY_UNIT cycles, then advances.
- The delay counter is ADDR-independent: 16-bit tick counter plus a unit counter of width clog2(DELAY_UNIT).
- `i2c_data` is stable from REQ entry until RUN exit.
- Asynchronous reset mid-transfer: outputs clear immediately. The `i2c` master shares the same reset.

## Test plan
- Table {W 98/03, W 41/10, END}, always-ACK model: exactly two transfers, data 0x729803 then 0x724110; `done`=1, `error`=0, `busy`=0.
- Table {S 7A, W 02/55, END}: `OP_SLAVE` causes no bus activity; one transfer with `i2c_data`=0x7A0255. After a restart, the first write uses 0x72 again.
- MAX_RETRY=3, model NACKs entry 0 always and entry 1 twice: entry 0 gets 4 attempts then is skipped; entry 1 gets 3 attempts then succeeds. End state `error`=1, `err_cnt`=1.
- DELAY_UNIT=10, {D 0003, W 10/20, END}: `i2c_start` first rises 30 cycles after DECODE of the delay entry, plus the FETCH/DECODE overhead of the next entry. {D 0000} adds no wait.
- Restart pulse during RUN of entry 2: the transfer completes, its NACK is ignored, and `tbl_addr` then returns to 0 with `err_cnt` cleared. Two pulses during the same RUN cause a single restart.
- Full table with no `OP_END` (ADDR_W=2, 4 writes): exactly 4 transfers, then FIN; `tbl_addr` never wraps to 0.
